pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the transducer PWM generator. Samples one PWM waveform in loopback
//  against the shared 9-bit TIME counter (period 512 ticks). Recovers pulse width (DUTY+DUTY_OFFSET)
//  and centre phase, for transducer self-test and readback through the controller.
// PARAMETERS
//  PHASE_INVERTED  "TRUE"  "TRUE": PHASE = 8'hFF - centre[8:1]; otherwise PHASE = centre[8:1]
//  TIMEOUT_WRAPS   2       TIME wraps (511->0) without any edge before STUCK asserts
// PORTS
//  CLK        in   1  system clock; TIME advances by one per CLK
//  RST        in   1  reset, synchronous, active-high
//  TIME       in   9  shared PWM cycle counter, 0..511, wraps
//  PWM_IN     in   1  PWM under test, same clock domain
//  WIDTH      out  9  measured high width in ticks, 0..256
//  PHASE      out  8  recovered phase code
//  VALID      out  1  one-cycle strobe: WIDTH/PHASE updated
//  STUCK      out  1  no edge seen for TIMEOUT_WRAPS periods
//  LEVEL      out  1  constant level of PWM_IN while STUCK
// BEHAVIOUR
//  - Reset: WIDTH=0, PHASE=0, VALID=0, STUCK=0, LEVEL=0; state=PRIME; wrap counter=0.
//  - Input stage: PWM_IN and TIME are registered together (s_pwm, s_time); all decisions use this stage.
//  - Edge timestamps:
//    - rise = s_pwm & ~prev; fall = ~s_pwm & prev; timestamp = s_time of that same sample.
//    - Generator pulse [P-DL, P+DR) gives rise at P-DL and fall at P+DR.
//  - FSM:
//    - PRIME: load prev from the first sample, detect no edge -> WAIT_RISE. A high PWM_IN at reset
//      is not a rise.
//    - WAIT_RISE: on rise, R <= s_time -> WAIT_FALL. Falls are ignored.
//    - WAIT_FALL: on fall, F <= s_time -> CALC.
//    - CALC (1 cycle): W = (F - R) mod 512; C = (R + W[8:1]) mod 512; register outputs -> WAIT_RISE.
//  - Latency: VALID is high in the cycle after CALC, i.e. 2 CLK after the fall sample is registered.
//  - Arithmetic: all 9-bit modulo 512, so pulses straddling TIME wrap (R > F) need no special case.
//    Odd W uses floor(W/2), matching the generator's DL = D>>1.
//  - Timeout:
//    - The wrap counter increments when s_time goes 511->0 with no edge in that cycle.
//      An edge in the same cycle wins and clears the counter.
//    - At TIMEOUT_WRAPS: STUCK=1, LEVEL=s_pwm, WIDTH = LEVEL ? 9'd256 : 9'd0 (saturated),
//      VALID pulses once; the counter holds.
//    - Any later edge clears STUCK and the counter; FSM continues normally.
//  - A rise in WAIT_FALL (impossible without an intervening fall) restarts: R <= s_time.
//  - VALID is never high two consecutive cycles.
//  - RST mid-measurement discards R/F and returns to PRIME within one cycle.
// STRUCTURE
//  - pwm_capture_pkg: typedef enum logic [1:0] {PRIME, WAIT_RISE, WAIT_FALL, CALC} cap_state_t;
//    localparam PERIOD = 512; localparam W_MAX = 256.
//  - Sub-module pwm_edge_detector: input registers, prev flop, rise/fall/wrap flags, aligned
//    timestamp. The top holds the FSM, arithmetic and timeout.
// TESTING (bench drives the generator with the same TIME and feeds its output to PWM_IN)
//  1 DUTY=0x80, offset 0, PHASE=0x40, not inverted -> R=0x040, F=0x0C0, WIDTH=0x080, PHASE=0x40, VALID x1 per period
//  2 DUTY=0x80, PHASE=0x00 (wrap) -> R=0x1C0, F=0x040, WIDTH=0x080, PHASE=0x00
//  3 DUTY=0x80, offset 1, PHASE=0x10 -> WIDTH=0x081, PHASE=0x10; DUTY=0xFF, offset 1 -> WIDTH=0x100
//  4 DUTY=0 -> no VALID for 2 wraps, then STUCK=1, LEVEL=0, WIDTH=0, single VALID; restore DUTY=0x80 -> STUCK clears at first edge
//  5 PHASE_INVERTED="TRUE", PHASE=0x30, DUTY=0x40 -> PHASE output 0x30, WIDTH=0x040
//  6 PWM_IN high at reset release; RST pulsed while in WAIT_FALL -> no spurious VALID, outputs zeroed, next full pulse measured correctly

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM loopback capture block.
// Phase code helper matches the transducer generator's mapping.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    PRIME,
    WAIT_RISE,
    WAIT_FALL,
    CALC
  } cap_state_t;

  localparam int PERIOD = 512;
  localparam int W_MAX  = 256;

  function automatic logic [7:0] phase_code(
    input logic [8:0] c,
    input logic       inv
  );
    return inv ? (8'hFF - c[8:1]) : c[8:1];
  endfunction

endpackage

// File: rtl/pwm_edge_detector.sv
// Input stage for pwm_capture: registers PWM and TIME together,
// flags edges and TIME wraps against the aligned timestamp.
module pwm_edge_detector
  import pwm_capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] time_cnt,
  input  logic       pwm_in,
  output logic       s_pwm,
  output logic [8:0] s_time,
  output logic       rise,
  output logic       fall,
  output logic       wrap,
  output logic       primed
);

  logic       prev;
  logic [8:0] prev_time;
  logic       s_vld;
  logic       p_vld;

  // sample stage plus one-deep history; edges only once history is real
  always_ff @(posedge clk) begin
    if (rst) begin
      s_pwm     <= 1'b0;
      s_time    <= 9'd0;
      prev      <= 1'b0;
      prev_time <= 9'd0;
      s_vld     <= 1'b0;
      p_vld     <= 1'b0;
    end else begin
      s_pwm     <= pwm_in;
      s_time    <= time_cnt;
      prev      <= s_pwm;
      prev_time <= s_time;
      s_vld     <= 1'b1;
      p_vld     <= s_vld;
    end
  end

  assign rise   = p_vld & s_pwm & ~prev;
  assign fall   = p_vld & ~s_pwm & prev;
  assign wrap   = p_vld
                & (prev_time == 9'(PERIOD - 1))
                & (s_time == 9'd0);
  assign primed = s_vld;

endmodule

// File: rtl/pwm_capture.sv
// Loopback PWM capture: recovers pulse width and centre phase
// against the shared 9-bit TIME counter, with a stuck-line timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter string PHASE_INVERTED = "TRUE",
  parameter int    TIMEOUT_WRAPS  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] TIME,
  input  logic       PWM_IN,
  output logic [8:0] WIDTH,
  output logic [7:0] PHASE,
  output logic       VALID,
  output logic       STUCK,
  output logic       LEVEL
);

  localparam logic INV = (PHASE_INVERTED == "TRUE");
  localparam int   CW  = (TIMEOUT_WRAPS < 1) ? 1
                       : $clog2(TIMEOUT_WRAPS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_WRAPS - 1);
  localparam logic [CW-1:0] FULL = CW'(TIMEOUT_WRAPS);

  logic          s_pwm;
  logic [8:0]    s_time;
  logic          rise;
  logic          fall;
  logic          wrap;
  logic          primed;

  cap_state_t    state;
  cap_state_t    nstate;
  logic          load_r;
  logic          load_f;
  logic          calc;

  logic [8:0]    r_q;
  logic [8:0]    f_q;
  logic [8:0]    w_calc;
  logic [8:0]    c_calc;

  logic [CW-1:0] cnt;
  logic          edge_any;
  logic          stuck_fire;

  pwm_edge_detector u_edge (
    .clk      (CLK),
    .rst      (RST),
    .time_cnt (TIME),
    .pwm_in   (PWM_IN),
    .s_pwm    (s_pwm),
    .s_time   (s_time),
    .rise     (rise),
    .fall     (fall),
    .wrap     (wrap),
    .primed   (primed)
  );

  // modulo-512 arithmetic handles pulses that straddle the TIME wrap
  assign w_calc     = f_q - r_q;
  assign c_calc     = r_q + {1'b0, w_calc[8:1]};
  assign edge_any   = rise | fall;
  assign stuck_fire = wrap & ~edge_any & (cnt == LAST);

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= PRIME;
    else     state <= nstate;
  end

  // next state and timestamp load strobes
  always_comb begin
    nstate = state;
    load_r = 1'b0;
    load_f = 1'b0;
    calc   = 1'b0;
    unique case (state)
      PRIME: begin
        if (primed) nstate = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          load_r = 1'b1;
          nstate = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (rise) begin
          load_r = 1'b1;
        end else if (fall) begin
          load_f = 1'b1;
          nstate = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (rise) begin
          load_r = 1'b1;
          nstate = WAIT_FALL;
        end else begin
          nstate = WAIT_RISE;
        end
      end
      default: nstate = PRIME;
    endcase
  end

  // rise/fall timestamps
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 9'd0;
      f_q <= 9'd0;
    end else begin
      if (load_r) r_q <= s_time;
      if (load_f) f_q <= s_time;
    end
  end

  // result registers, strobe and wrap-count timeout
  always_ff @(posedge CLK) begin
    if (RST) begin
      WIDTH <= 9'd0;
      PHASE <= 8'd0;
      VALID <= 1'b0;
      STUCK <= 1'b0;
      LEVEL <= 1'b0;
      cnt   <= '0;
    end else begin
      VALID <= (calc | stuck_fire) & ~VALID;
      if (calc) begin
        WIDTH <= w_calc;
        PHASE <= phase_code(c_calc, INV);
      end
      if (edge_any) begin
        cnt   <= '0;
        STUCK <= 1'b0;
      end else if (wrap && cnt != FULL) begin
        cnt <= cnt + CW'(1);
      end
      if (stuck_fire) begin
        STUCK <= 1'b1;
        LEVEL <= s_pwm;
        WIDTH <= s_pwm ? 9'(W_MAX) : 9'd0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: behavioural generator in loopback,
// one plain-phase and one inverted-phase instance side by side.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] tcnt;
  logic       pwm;
  int         duty;
  int         off;
  int         code;

  logic [8:0] wn, wi;
  logic [7:0] pn, pi_;
  logic       vn, vi, sn, si, ln, li;

  int checks = 0;
  int errors = 0;

  pwm_capture #(
    .PHASE_INVERTED ("FALSE"),
    .TIMEOUT_WRAPS  (2)
  ) dut_n (
    .CLK    (clk),
    .RST    (rst),
    .TIME   (tcnt),
    .PWM_IN (pwm),
    .WIDTH  (wn),
    .PHASE  (pn),
    .VALID  (vn),
    .STUCK  (sn),
    .LEVEL  (ln)
  );

  pwm_capture #(
    .PHASE_INVERTED ("TRUE"),
    .TIMEOUT_WRAPS  (2)
  ) dut_i (
    .CLK    (clk),
    .RST    (rst),
    .TIME   (tcnt),
    .PWM_IN (pwm),
    .WIDTH  (wi),
    .PHASE  (pi_),
    .VALID  (vi),
    .STUCK  (si),
    .LEVEL  (li)
  );

  always #5 clk = ~clk;

  // generator: pulse of w ticks centred on 2*code, left half floor(w/2)
  function automatic logic gen(
    input logic [8:0] t,
    input int         d,
    input int         o,
    input int         c
  );
    int w;
    int r;
    w = d + o;
    r = (2 * c - w / 2 + 1024) % 512;
    return ((int'(t) - r + 512) % 512) < w;
  endfunction

  // TIME value at the fall edge of the generated pulse
  function automatic int fall_time(
    input int d,
    input int o,
    input int c
  );
    int w;
    w = d + o;
    return (2 * c - w / 2 + w + 1024) % 512;
  endfunction

  always_comb pwm = gen(tcnt, duty, off, code);

  initial begin
    tcnt = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 9'd1;
    end
  end

  // waits for the (skip+1)-th VALID; also watches strobe shape
  task automatic grab(
    input  int skip,
    input  int budget,
    output bit ok,
    output int cyc
  );
    int seen;
    bit pv;
    seen = 0;
    pv   = 1'b0;
    ok   = 1'b0;
    cyc  = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (vn || vi) begin
        checks++;
        if (vi !== vn || pv) begin
          errors++;
          $display("FAIL strobe: vn=%b vi=%b prev=%b, need aligned 1-cycle",
                   vn, vi, pv);
        end
      end
      pv = vn;
      if (vn) begin
        if (seen == skip) ok = 1'b1;
        seen++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: no VALID in %0d cycles", budget);
    end
  endtask

  task automatic wait_time(input logic [8:0] t);
    int n;
    n = 0;
    while (tcnt !== t && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tcnt !== t) begin
      errors++;
      $display("FAIL wait_time: got %h need %h", tcnt, t);
    end
  endtask

  task automatic test_reset;
    duty = 8'h80;
    off  = 0;
    code = 8'h40;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wn, pn, vn, sn, ln} !== 20'd0) begin
      errors++;
      $display("FAIL reset_n: w=%h p=%h v=%b s=%b l=%b need all 0",
               wn, pn, vn, sn, ln);
    end
    checks++;
    if ({wi, pi_, vi, si, li} !== 20'd0) begin
      errors++;
      $display("FAIL reset_i: w=%h p=%h v=%b s=%b l=%b need all 0",
               wi, pi_, vi, si, li);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    int n;
    grab(1, 1700, ok, cyc);
    if (ok) begin
      checks++;
      if (wn !== 9'h080) begin
        errors++;
        $display("FAIL basic_width: got %h need 080", wn);
      end
      checks++;
      if (pn !== 8'h40 || pi_ !== 8'hBF) begin
        errors++;
        $display("FAIL basic_phase: got %h/%h need 40/bf", pn, pi_);
      end
      checks++;
      if (tcnt !== 9'h0C3) begin
        errors++;
        $display("FAIL basic_latency: time %h need 0c3", tcnt);
      end
    end
    n = 0;
    repeat (512) begin
      @(negedge clk);
      if (vn) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL basic_rate: %0d VALIDs per period need 1", n);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int cyc;
    code = 8'h00;
    grab(1, 1700, ok, cyc);
    if (ok) begin
      checks++;
      if (wn !== 9'h080 || pn !== 8'h00 || pi_ !== 8'hFF) begin
        errors++;
        $display("FAIL wrap_meas: w=%h p=%h/%h need 080 00/ff",
                 wn, pn, pi_);
      end
      checks++;
      if (tcnt !== 9'h043) begin
        errors++;
        $display("FAIL wrap_latency: time %h need 043", tcnt);
      end
    end
  endtask

  task automatic test_offset;
    bit ok;
    int cyc;
    duty = 8'h80;
    off  = 1;
    code = 8'h10;
    grab(1, 1700, ok, cyc);
    if (ok) begin
      checks++;
      if (wn !== 9'h081 || pn !== 8'h10) begin
        errors++;
        $display("FAIL offset_odd: w=%h p=%h need 081 10", wn, pn);
      end
    end
    duty = 8'hFF;
    grab(1, 1700, ok, cyc);
    if (ok) begin
      checks++;
      if (wn !== 9'h100 || pn !== 8'h10 || wi !== 9'h100) begin
        errors++;
        $display("FAIL offset_max: w=%h/%h p=%h need 100 10",
                 wn, wi, pn);
      end
    end
  endtask

  task automatic test_stuck;
    bit ok;
    int cyc;
    int n;
    duty = 8'h80;
    off  = 0;
    code = 8'h40;
    grab(1, 1700, ok, cyc);
    duty = 0;
    grab(0, 1200, ok, cyc);
    if (ok) begin
      checks++;
      if (sn !== 1'b1 || si !== 1'b1 || ln !== 1'b0 || wn !== 9'd0) begin
        errors++;
        $display("FAIL stuck_flag: s=%b/%b l=%b w=%h need 1/1 0 000",
                 sn, si, ln, wn);
      end
      checks++;
      if (cyc <= 512 || tcnt !== 9'h002) begin
        errors++;
        $display("FAIL stuck_timing: cyc=%0d time=%h need >512 at 002",
                 cyc, tcnt);
      end
    end
    n = 0;
    repeat (600) begin
      @(negedge clk);
      if (vn) n++;
    end
    checks++;
    if (n != 0 || sn !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: %0d extra VALIDs stuck=%b need 0 1",
               n, sn);
    end
    wait_time(9'h100);
    duty = 8'h80;
    n = 0;
    while (sn === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sn !== 1'b0 || tcnt !== 9'h042) begin
      errors++;
      $display("FAIL stuck_clear: stuck=%b time=%h need 0 at 042",
               sn, tcnt);
    end
    grab(0, 1100, ok, cyc);
    if (ok) begin
      checks++;
      if (wn !== 9'h080 || pn !== 8'h40 || sn !== 1'b0) begin
        errors++;
        $display("FAIL stuck_resume: w=%h p=%h s=%b need 080 40 0",
                 wn, pn, sn);
      end
    end
  endtask

  task automatic test_inverted;
    bit ok;
    int cyc;
    duty = 8'h40;
    off  = 0;
    code = 8'hCF;
    grab(1, 1700, ok, cyc);
    if (ok) begin
      checks++;
      if (pi_ !== 8'h30 || wi !== 9'h040 || pn !== 8'hCF) begin
        errors++;
        $display("FAIL inverted: p=%h w=%h plain=%h need 30 040 cf",
                 pi_, wi, pn);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc;
    duty = 8'h80;
    off  = 0;
    code = 8'h40;
    grab(1, 1700, ok, cyc);
    wait_time(9'h060);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wn, pn, vn, sn, ln} !== 20'd0) begin
      errors++;
      $display("FAIL midrst_zero: w=%h p=%h v=%b need 0", wn, pn, vn);
    end
    rst = 1'b0;
    grab(0, 1100, ok, cyc);
    if (ok) begin
      checks++;
      if (cyc <= 300 || tcnt !== 9'h0C3) begin
        errors++;
        $display("FAIL midrst_spur: cyc=%0d time=%h need >300 at 0c3",
                 cyc, tcnt);
      end
      checks++;
      if (wn !== 9'h080 || pn !== 8'h40) begin
        errors++;
        $display("FAIL midrst_meas: w=%h p=%h need 080 40", wn, pn);
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int cyc;
    int ef;
    for (int k = 0; k < 6; k++) begin
      duty = $urandom_range(1, 255);
      off  = $urandom_range(0, 1);
      code = $urandom_range(0, 255);
      ef   = (fall_time(duty, off, code) + 3) % 512;
      grab(1, 1700, ok, cyc);
      if (ok) begin
        checks++;
        if (wn !== 9'(duty + off) || pn !== 8'(code)
            || pi_ !== 8'(255 - code)) begin
          errors++;
          $display("FAIL rand_meas: w=%h p=%h/%h need %h %h/%h",
                   wn, pn, pi_, 9'(duty + off), 8'(code),
                   8'(255 - code));
        end
        checks++;
        if (tcnt !== 9'(ef)) begin
          errors++;
          $display("FAIL rand_latency: time %h need %h", tcnt, 9'(ef));
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    duty = 0;
    off  = 0;
    code = 0;
    test_reset;
    test_basic;
    test_wrap;
    test_offset;
    test_stuck;
    test_inverted;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
